// File: rtl/m_am_dmem_arb.sv
// m_am_dmem_arb: round-robin arbiter giving core (port 0) and loader (port 1) turns on the shared dmem
// One owner at a time; bursts are cut after MAX_HOLD cycles when the other port is waiting.
module m_am_dmem_arb #(
    parameter int MAX_HOLD = 16
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_req0,
    input  logic        w_we0,
    input  logic        w_last0,
    input  logic [31:0] w_adr0,
    input  logic [31:0] w_wd0,
    output logic        w_gnt0,
    output logic [31:0] w_rd0,
    output logic        w_rv0,
    input  logic        w_req1,
    input  logic        w_we1,
    input  logic        w_last1,
    input  logic [31:0] w_adr1,
    input  logic [31:0] w_wd1,
    output logic        w_gnt1,
    output logic [31:0] w_rd1,
    output logic        w_rv1,
    output logic [31:0] w_madr,
    output logic        w_mwe,
    output logic [31:0] w_mwd,
    input  logic [31:0] w_mrd
);
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nx;
    logic          ptr, ptr_nx;
    logic [HW-1:0] hc, hc_nx;
    logic          oreq, rel;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            hc    <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            hc    <= hc_nx;
        end
    end

    // the owner lets go after its last beat, or once its hold budget is spent while the other port waits
    always_comb begin
        oreq     = (state == OWN0) ? w_req1 : w_req0;
        rel      = ((state == OWN0) ? (w_gnt0 & w_last0) : (w_gnt1 & w_last1)) | ((hc == HMAX) & oreq);
        state_nx = state;
        ptr_nx   = ptr;
        hc_nx    = hc;
        if (state == IDLE) begin
            state_nx = (w_req0 & w_req1) ? (ptr ? OWN1 : OWN0) : w_req0 ? OWN0 : w_req1 ? OWN1 : IDLE;
        end else if (rel) begin
            state_nx = oreq ? ((state == OWN0) ? OWN1 : OWN0) : IDLE;
            ptr_nx   = (state == OWN0);
            hc_nx    = '0;
        end else begin
            hc_nx = (hc == HMAX) ? hc : hc + 1'b1;
        end
    end

    always_comb begin
        w_gnt0 = (state == OWN0) & w_req0 & ~w_rst;
        w_gnt1 = (state == OWN1) & w_req1 & ~w_rst;
        w_madr = (state == OWN1) ? w_adr1 : w_adr0;
        w_mwd  = (state == OWN1) ? w_wd1 : w_wd0;
        w_mwe  = (w_gnt0 & w_we0) | (w_gnt1 & w_we1);
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            w_rv0 <= 1'b0;
            w_rv1 <= 1'b0;
            w_rd0 <= '0;
            w_rd1 <= '0;
        end else begin
            w_rv0 <= w_gnt0 & ~w_we0;
            w_rv1 <= w_gnt1 & ~w_we1;
            if (w_gnt0 & ~w_we0) w_rd0 <= w_mrd;
            if (w_gnt1 & ~w_we1) w_rd1 <= w_mrd;
        end
    end
endmodule

// File: tb/tb_m_am_dmem_arb.sv
// tb_m_am_dmem_arb: randomized scoreboard bench for the two-port dmem arbiter
// A cycle-level ownership model predicts grants and memory traffic; read data is checked through queues.
`timescale 1ns/1ps
module tb_m_am_dmem_arb;
    localparam int MAX_HOLD = 16;

    logic        w_clk = 1'b0, w_rst = 1'b1;
    logic        w_req0 = 1'b0, w_we0 = 1'b0, w_last0 = 1'b0;
    logic        w_req1 = 1'b0, w_we1 = 1'b0, w_last1 = 1'b0;
    logic [31:0] w_adr0 = '0, w_wd0 = '0, w_adr1 = '0, w_wd1 = '0;
    logic        w_gnt0, w_gnt1, w_rv0, w_rv1, w_mwe;
    logic [31:0] w_rd0, w_rd1, w_madr, w_mwd, w_mrd;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    int          vec = 0, bad = 0, cyc = 0;
    logic [31:0] mem [64];
    logic [31:0] gmem [64];
    bit          mem_init = 1'b1;
    exp_t        q0[$], q1[$];
    int          own = -1, ptr_m = 0, held = 0;
    bit          rst_prev = 1'b0, dg0, dg1, dmwe;

    m_am_dmem_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_req0(w_req0), .w_we0(w_we0), .w_last0(w_last0), .w_adr0(w_adr0), .w_wd0(w_wd0),
        .w_gnt0(w_gnt0), .w_rd0(w_rd0), .w_rv0(w_rv0),
        .w_req1(w_req1), .w_we1(w_we1), .w_last1(w_last1), .w_adr1(w_adr1), .w_wd1(w_wd1),
        .w_gnt1(w_gnt1), .w_rd1(w_rd1), .w_rv1(w_rv1),
        .w_madr(w_madr), .w_mwe(w_mwe), .w_mwd(w_mwd), .w_mrd(w_mrd)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] seed(input int i);
        return 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    endfunction

    // the data memory the arbiter fronts: combinational read, write at the grant edge
    assign w_mrd = mem[w_madr[7:2]];
    always @(posedge w_clk)
        if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= seed(i);
        else if (w_mwe) mem[w_madr[7:2]] <= w_mwd;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vec++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, a, e);
        end
    endtask

    // who owns the memory, whose turn a tie is, and how long the owner has held it
    task automatic model_cycle();
        bit          e0, e1, ewe, rel, oreq;
        logic [31:0] eadr, ewd;
        int          oth;
        e0   = !w_rst && own == 0 && w_req0;
        e1   = !w_rst && own == 1 && w_req1;
        eadr = (own == 1) ? w_adr1 : w_adr0;
        ewd  = (own == 1) ? w_wd1 : w_wd0;
        ewe  = (e0 && w_we0) || (e1 && w_we1);
        dg0  = w_gnt0;
        dg1  = w_gnt1;
        dmwe = w_mwe;
        chk("gnt0", 32'(w_gnt0), 32'(e0));
        chk("gnt1", 32'(w_gnt1), 32'(e1));
        chk("mwe", 32'(w_mwe), 32'(ewe));
        chk("madr", w_madr, eadr);
        chk("mwd", w_mwd, ewd);
        if (rst_prev) begin
            chk("rst_rv", 32'({w_rv1, w_rv0}), 32'd0);
            chk("rst_rd0", w_rd0, 32'd0);
            chk("rst_rd1", w_rd1, 32'd0);
        end
        if (e0 && !w_we0) q0.push_back('{gmem[w_adr0[7:2]], cyc});
        if (e1 && !w_we1) q1.push_back('{gmem[w_adr1[7:2]], cyc});
        if (ewe) gmem[eadr[7:2]] = ewd;
        if (w_rst) begin
            own = -1; ptr_m = 0; held = 0;
        end else if (own < 0) begin
            own = (w_req0 && w_req1) ? ptr_m : w_req0 ? 0 : w_req1 ? 1 : -1;
        end else begin
            oth  = 1 - own;
            oreq = (oth == 0) ? w_req0 : w_req1;
            rel  = (own == 0 ? (e0 && w_last0) : (e1 && w_last1)) || (held == MAX_HOLD - 1 && oreq);
            if (rel) begin
                ptr_m = oth; held = 0; own = oreq ? oth : -1;
            end else if (held < MAX_HOLD - 1) begin
                held++;
            end
        end
        rst_prev = w_rst;
    endtask

    task automatic step();
        @(negedge w_clk);
        model_cycle();
        @(posedge w_clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        w_rst = 1'b1;
        repeat (n) step();
        w_rst = 1'b0;
    endtask

    task automatic beat(input int p, input bit we, input logic [31:0] adr, input logic [31:0] wd,
                        input bit last, output int n);
        n = 0;
        if (p == 0) begin w_req0 = 1'b1; w_we0 = we; w_adr0 = adr; w_wd0 = wd; w_last0 = last; end
        else        begin w_req1 = 1'b1; w_we1 = we; w_adr1 = adr; w_wd1 = wd; w_last1 = last; end
        do begin step(); n++; end while (!(p == 0 ? dg0 : dg1) && n < 64);
        if (p == 0) w_req0 = 1'b0; else w_req1 = 1'b0;
        if (n >= 64) begin
            vec++; bad++;
            $display("FAIL beat_timeout port %0d: got no grant, expected one within 64 cycles", p);
        end
    endtask

    // read returns: exactly one cycle after the modelled read grant
    always @(negedge w_clk) begin
        if (w_rv0) begin
            if (q0.size() == 0 || q0[0].c != cyc - 1) chk("rv0_unexpected", 32'(w_rv0), 32'd0);
            else begin chk("rd0", w_rd0, q0[0].d); void'(q0.pop_front()); end
        end else if (q0.size() > 0 && q0[0].c == cyc - 1) begin
            chk("rv0_missing", 32'(w_rv0), 32'd1); void'(q0.pop_front());
        end
        if (w_rv1) begin
            if (q1.size() == 0 || q1[0].c != cyc - 1) chk("rv1_unexpected", 32'(w_rv1), 32'd0);
            else begin chk("rd1", w_rd1, q1[0].d); void'(q1.pop_front()); end
        end else if (q1.size() > 0 && q1[0].c == cyc - 1) begin
            chk("rv1_missing", 32'(w_rv1), 32'd1); void'(q1.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, run, b1, gaps;
        bit got0, started;
        for (int i = 0; i < 64; i++) gmem[i] = seed(i);
        w_req0 = 1'b1; w_req1 = 1'b1; w_last0 = 1'b1; w_last1 = 1'b1;
        step();
        mem_init = 1'b0;
        step();
        w_rst = 1'b0;
        step();
        step();
        chk("rst_pick0", 32'(dg0), 32'd1);
        w_req0 = 1'b0; w_req1 = 1'b0;
        do_reset(1);

        beat(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, n);
        chk("wr_lat", n, 2);
        beat(0, 1'b0, 32'h10, 32'h0, 1'b1, n);
        chk("rd_lat", n, 2);
        step();
        step();

        do_reset(1);
        w_req0 = 1'b1; w_req1 = 1'b1; w_last0 = 1'b1; w_last1 = 1'b1;
        gaps = 0; started = 1'b0;
        for (int i = 0; i < 24; i++) begin
            w_we0 = 1'($urandom); w_we1 = 1'($urandom);
            w_adr0 = $urandom; w_adr1 = $urandom; w_wd0 = $urandom; w_wd1 = $urandom;
            step();
            if (started && !dg0 && !dg1) gaps++;
            if (dg0 || dg1) started = 1'b1;
        end
        chk("tie_gaps", gaps, 0);
        w_req0 = 1'b0; w_req1 = 1'b0;
        do_reset(1);

        run = 0; b1 = 0; got0 = 1'b0;
        w_last1 = 1'b0; w_last0 = 1'b1; w_we0 = 1'b0;
        for (int i = 0; i < 120 && b1 < 40; i++) begin
            w_req1 = 1'b1; w_we1 = 1'($urandom); w_adr1 = $urandom; w_wd1 = $urandom;
            w_req0 = (i >= 5) && !got0; w_adr0 = $urandom;
            step();
            if (dg1) b1++;
            if (dg0) got0 = 1'b1;
            if (dg1 && !got0) run++;
        end
        chk("hold_run", run, MAX_HOLD);
        chk("burst_beats", b1, 40);
        w_req0 = 1'b0; w_req1 = 1'b0;
        do_reset(1);

        w_req1 = 1'b1; w_we1 = 1'b1; w_last1 = 1'b0; w_adr1 = 32'h24;
        b1 = 0;
        for (int i = 0; i < 20 && b1 < 3; i++) begin
            w_wd1 = $urandom;
            step();
            if (dg1) b1++;
        end
        w_rst = 1'b1; w_adr1 = 32'h28; w_wd1 = 32'h1234_5678;
        step();
        chk("rst_mwe", 32'(dmwe), 32'd0);
        w_rst = 1'b0;
        w_req0 = 1'b1; w_we0 = 1'b0; w_last0 = 1'b1; w_adr0 = 32'h28;
        w_we1 = 1'b0; w_last1 = 1'b1; w_adr1 = 32'h24;
        step();
        step();
        chk("post_rst_tie0", 32'(dg0), 32'd1);
        w_req0 = 1'b0; w_req1 = 1'b0;
        step();
        do_reset(1);

        beat(0, 1'b1, 32'h30, $urandom, 1'b0, n);
        repeat (30) step();
        beat(1, 1'b0, 32'h30, 32'h0, 1'b1, n);
        chk("idle_hold_lat", n, 2);
        step();

        for (int i = 0; i < 800; i++) begin
            w_rst   = ($urandom_range(0, 99) == 0);
            w_req0  = ($urandom_range(0, 3) != 0);
            w_req1  = ($urandom_range(0, 3) != 0);
            w_we0   = 1'($urandom);
            w_we1   = 1'($urandom);
            w_last0 = ($urandom_range(0, 2) == 0);
            w_last1 = ($urandom_range(0, 2) == 0);
            w_adr0  = $urandom; w_adr1 = $urandom;
            w_wd0   = $urandom; w_wd1  = $urandom;
            step();
        end
        w_rst = 1'b0; w_req0 = 1'b0; w_req1 = 1'b0;
        repeat (3) step();
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
